// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low HEX codes, blank pattern, capture FSM states.
// The optional tens counter in seg7_capture is enabled by defining SEG7_CAPTURE_TENS_EN.
package seg7_pkg;

    localparam int CNT_W = 20;

    // Active-low segment codes, bit0 = a ... bit6 = g, same table as the HEX0 encoder.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } cap_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the HEX encoder: segment pattern to 4-bit value,
// with a match flag for legal digits and a blank flag for the all-off pattern.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       match,
    output logic       blank
);

    always_comb begin
        value = 4'h0;
        match = 1'b1;
        case (seg)
            SEG_0:   value = 4'h0;
            SEG_1:   value = 4'h1;
            SEG_2:   value = 4'h2;
            SEG_3:   value = 4'h3;
            SEG_4:   value = 4'h4;
            SEG_5:   value = 4'h5;
            SEG_6:   value = 4'h6;
            SEG_7:   value = 4'h7;
            SEG_8:   value = 4'h8;
            SEG_9:   value = 4'h9;
            SEG_A:   value = 4'hA;
            SEG_B:   value = 4'hB;
            SEG_C:   value = 4'hC;
            SEG_D:   value = 4'hD;
            SEG_E:   value = 4'hE;
            SEG_F:   value = 4'hF;
            default: match = 1'b0;
        endcase
        blank = (seg == SEG_BLANK);
    end

endmodule

// File: rtl/seg7_capture.sv
// Debounced capture of an asynchronous active-low 7-segment bus into a hex digit.
// Define SEG7_CAPTURE_TENS_EN to add the tens counter and wrap pulse (9 -> 0 carries).
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             update,
    output logic             illegal,
    output logic [7:0]       illegal_cnt,
`ifdef SEG7_CAPTURE_TENS_EN
    output logic [3:0]       tens,
    output logic             wrap,
`endif
    output cap_state_t       state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       seg_m;
    logic [6:0]       seg_s;
    logic [6:0]       last;
    logic [CNT_W-1:0] cnt;
    cap_state_t       state;

    logic [3:0]       dec_value;
    logic             dec_match;
    logic             dec_blank;

    // Two-flop synchronizer; seg_in changes freely relative to CLOCK_50.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_m <= '0;
            seg_s <= '0;
        end else begin
            seg_m <= seg_in;
            seg_s <= seg_m;
        end
    end

    // Decode the held pattern; at accept time seg_s == last, so both are equivalent.
    seg7_to_hex u_dec (
        .seg   (last),
        .value (dec_value),
        .match (dec_match),
        .blank (dec_blank)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= SETTLE;
            last        <= '0;
            cnt         <= '0;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            update      <= 1'b0;
            illegal     <= 1'b0;
            illegal_cnt <= 8'h00;
`ifdef SEG7_CAPTURE_TENS_EN
            tens        <= 4'h0;
            wrap        <= 1'b0;
`endif
        end else begin
            update <= 1'b0;
`ifdef SEG7_CAPTURE_TENS_EN
            wrap   <= 1'b0;
`endif
            case (state)
                SETTLE: begin
                    if (seg_s != last) begin
                        cnt  <= '0;
                        last <= seg_s;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOCKED;
                        if (dec_match) begin
                            digit       <= dec_value;
                            digit_valid <= 1'b1;
                            illegal     <= 1'b0;
                            if (!digit_valid || (digit != dec_value)) begin
                                update <= 1'b1;
                            end
`ifdef SEG7_CAPTURE_TENS_EN
                            if ((dec_value == 4'h0) && digit_valid && (digit == 4'h9)) begin
                                tens <= (tens == 4'h9) ? 4'h0 : tens + 4'h1;
                                wrap <= 1'b1;
                            end
`endif
                        end else if (dec_blank) begin
                            digit_valid <= 1'b0;
                            illegal     <= 1'b0;
                        end else begin
                            digit_valid <= 1'b0;
                            illegal     <= 1'b1;
                            if (illegal_cnt != 8'hFF) begin
                                illegal_cnt <= illegal_cnt + 8'h01;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    // Counter holds here so a pattern held forever is accepted once.
                    if (seg_s != last) begin
                        cnt   <= '0;
                        last  <= seg_s;
                        state <= SETTLE;
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: run-length reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_seg7_capture;

    localparam int STABLE = 4;

    logic       CLOCK_50;
    logic       RESET_N;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic       update;
    logic       illegal;
    logic [7:0] illegal_cnt;
`ifdef SEG7_CAPTURE_TENS_EN
    logic [3:0] tens;
    logic       wrap;
`endif
    seg7_pkg::cap_state_t state_dbg;

    seg7_capture #(.STABLE_CYCLES(STABLE)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .seg_in      (seg_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .update      (update),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt),
`ifdef SEG7_CAPTURE_TENS_EN
        .tens        (tens),
        .wrap        (wrap),
`endif
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model
    logic [6:0] hex_codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int m_digit, m_valid, m_illegal, m_cnt, m_update, m_tens, m_wrap;
    int run_len;
    logic [6:0] prev_v, p1_v, p2_v;
    bit prev_ok, p1_ok, p2_ok;
    int p1_len, p2_len;

    function automatic int decode(input logic [6:0] p);
        if (p == 7'h7F) return -2;
        for (int i = 0; i < 16; i++) if (p == hex_codes[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_digit = 0; m_valid = 0; m_illegal = 0; m_cnt = 0; m_update = 0;
        m_tens = 0; m_wrap = 0;
        run_len = 0; prev_ok = 0; p1_ok = 0; p2_ok = 0;
        prev_v = '0; p1_v = '0; p2_v = '0; p1_len = 0; p2_len = 0;
    endtask

    task automatic model_accept(input logic [6:0] p);
        int v;
        v = decode(p);
        if (v >= 0) begin
            if (m_valid == 0 || m_digit != v) m_update = 1;
            if (v == 0 && m_valid == 1 && m_digit == 9) begin
                m_tens = (m_tens + 1) % 10;
                m_wrap = 1;
            end
            m_digit = v; m_valid = 1; m_illegal = 0;
        end else if (v == -2) begin
            m_valid = 0; m_illegal = 0;
        end else begin
            m_valid = 0; m_illegal = 1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    // A pattern is accepted when its sampled run reaches exactly STABLE+1 samples,
    // seen by the outputs two edges later because of the synchronizer.
    always @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            model_reset();
        end else begin
            m_update = 0; m_wrap = 0;
            if (p2_ok && p2_len == STABLE + 1) model_accept(p2_v);
            p2_ok = p1_ok; p2_v = p1_v; p2_len = p1_len;
            if (prev_ok && seg_in == prev_v) run_len++;
            else run_len = 1;
            prev_v = seg_in; prev_ok = 1;
            p1_v = seg_in; p1_len = run_len; p1_ok = 1;
        end
        #1;
        check("digit", int'(digit), m_digit);
        check("digit_valid", int'(digit_valid), m_valid);
        check("update", int'(update), m_update);
        check("illegal", int'(illegal), m_illegal);
        check("illegal_cnt", int'(illegal_cnt), m_cnt);
`ifdef SEG7_CAPTURE_TENS_EN
        check("tens", int'(tens), m_tens);
        check("wrap", int'(wrap), m_wrap);
`endif
    end

    // driver tasks
    int upd_seen;
    int wrap_seen;

    task automatic run(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            if (update) upd_seen++;
`ifdef SEG7_CAPTURE_TENS_EN
            if (wrap) wrap_seen++;
`endif
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        run(n);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_digit"}, int'(digit), 0);
        check({tag, "_valid"}, int'(digit_valid), 0);
        check({tag, "_update"}, int'(update), 0);
        check({tag, "_illegal"}, int'(illegal), 0);
        check({tag, "_cnt"}, int'(illegal_cnt), 0);
`ifdef SEG7_CAPTURE_TENS_EN
        check({tag, "_tens"}, int'(tens), 0);
        check({tag, "_wrap"}, int'(wrap), 0);
`endif
    endtask

    logic [6:0] tens_seq [6] = '{7'h00, 7'h10, 7'h40, 7'h79, 7'h10, 7'h40};
    logic [6:0] rnd_pool [20] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                                  7'h7F, 7'h7E, 7'h55, 7'h2A};

    initial begin
        RESET_N = 1'b0;
        seg_in  = 7'h30;
        upd_seen = 0; wrap_seen = 0;
        run(3);
        check_zero_outputs("reset");

        // Digit 3 from edge 0: accepted at edge 6 with a one-cycle update.
        RESET_N = 1'b1;
        run(STABLE + 2);
        check("e5_valid", int'(digit_valid), 0);
        check("e5_update", int'(update), 0);
        run(1);
        check("e6_digit", int'(digit), 3);
        check("e6_valid", int'(digit_valid), 1);
        check("e6_update", int'(update), 1);
        run(1);
        check("e7_update", int'(update), 0);
        upd_seen = 0;
        run(100);
        check("hold_no_update", upd_seen, 0);

        // Short glitch to 2 never reaches the outputs.
        hold(7'h24, 2);
        hold(7'h30, 20);
        check("glitch_digit", int'(digit), 3);
        check("glitch_cnt", int'(illegal_cnt), 0);
        check("glitch_no_update", upd_seen, 0);

        hold(7'h7E, 10);
        check("illegal_flag", int'(illegal), 1);
        check("illegal_valid", int'(digit_valid), 0);
        check("illegal_digit", int'(digit), 3);
        check("illegal_cnt1", int'(illegal_cnt), 1);
        hold(7'h7F, 10);
        check("blank_illegal", int'(illegal), 0);
        check("blank_valid", int'(digit_valid), 0);
        check("blank_cnt", int'(illegal_cnt), 1);

        for (int i = 0; i < 300; i++) hold((i % 2) ? 7'h7D : 7'h7E, 6);
        run(10);
        check("sat_cnt", int'(illegal_cnt), 255);
        check("sat_illegal", int'(illegal), 1);

        // 8 9 0 1 9 0 then 9 blank 0.
        upd_seen = 0; wrap_seen = 0;
        for (int i = 0; i < 6; i++) hold(tens_seq[i], 10);
        check("seq_updates", upd_seen, 6);
        check("seq_digit", int'(digit), 0);
`ifdef SEG7_CAPTURE_TENS_EN
        check("seq_wraps", wrap_seen, 2);
        check("seq_tens", int'(tens), 2);
`endif
        upd_seen = 0; wrap_seen = 0;
        hold(7'h10, 10);
        hold(7'h7F, 10);
        hold(7'h40, 10);
        check("brk_updates", upd_seen, 2);
`ifdef SEG7_CAPTURE_TENS_EN
        check("brk_wraps", wrap_seen, 0);
        check("brk_tens", int'(tens), 2);
`endif

        // Reset while settling on 3 with cnt == 2.
        hold(7'h12, 10);
        check("pre_rst_digit", int'(digit), 5);
        seg_in = 7'h30;
        run(5);
        RESET_N = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        run(1);
        RESET_N = 1'b1;
        upd_seen = 0;
        run(STABLE + 2);
        check("rel_early_valid", int'(digit_valid), 0);
        check("rel_early_updates", upd_seen, 0);
        run(1);
        check("rel_digit", int'(digit), 3);
        check("rel_valid", int'(digit_valid), 1);
        check("rel_update", int'(update), 1);
        upd_seen = 0;
        run(30);
        check("rel_single_accept", upd_seen, 0);

        // Randomized patterns with random hold lengths, checked by the model.
        for (int i = 0; i < 400; i++) begin
            hold(rnd_pool[$urandom_range(0, 19)], $urandom_range(1, 8));
        end
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the on-board hex-to-7-segment display path. It samples an active-low 7-segment pattern bus, for example one driven by another board's HEX output, and waits until the pattern has been stable long enough. It then decodes the pattern back to a 4-bit hex digit and reports validity, change events and illegal patterns. It sits between a GPIO header and any logic that needs the digit numerically, such as a checker or a tens counter.

## Interface
- STABLE_CYCLES, 1000: consecutive clocks a synchronized pattern must hold before acceptance; legal range 2..2^20.
- CLOCK_50  in  1: system clock, 50 MHz.
- RESET_N  in  1: asynchronous active-low reset. Asserts asynchronously; all state clears while low.
- seg_in  in  7: active-low segments. Bit0 = a, bit1 = b, …, bit6 = g, using the same encoding as HEX0. Asynchronous to CLOCK_50.
- digit  out  4: last accepted decoded value. Reset 4'h0.
- digit_valid  out  1: level. High when the last accepted pattern was a legal digit. Reset 0.
- update  out  1: one-cycle pulse when an accepted digit differs from the previous one, or when digit_valid rises. Reset 0.
- illegal  out  1: level. High when the last accepted pattern matched no digit and was not blank. Reset 0.
- illegal_cnt  out  8: count of illegal acceptances, saturating at 255. Reset 0.
- tens  out  4: present only with SEG7_CAPTURE_TENS_EN. Reset 0.
- wrap  out  1: present only with SEG7_CAPTURE_TENS_EN. Reset 0.

## Operation
- 2-flop synchronizer on seg_in produces seg_s.
- Registered `last` holds the previous seg_s; 20-bit stability counter `cnt`.
- FSM states:
  - SETTLE (reset state): if seg_s != last, then cnt <= 0 and last <= seg_s. Otherwise cnt increments. When cnt == STABLE_CYCLES-1 with seg_s == last, perform an accept and go to LOCKED.
  - LOCKED: hold cnt. If seg_s != last, then cnt <= 0, last <= seg_s, and go to SETTLE.
- Exactly one accept per stable period; a pattern held indefinitely is accepted once.
- Accept on a legal pattern (one of the 16 HEX0 codes):
  - digit <= value, digit_valid <= 1, illegal <= 0.
  - update pulses if the old digit_valid was 0 or the old digit != value.
- Accept on the blank pattern 7'h7F: digit_valid <= 0, illegal <= 0, digit held, no update, no count.
- Accept on any other pattern: illegal <= 1, digit_valid <= 0, digit held, no update. illegal_cnt increments unless it is already 255.
- Glitches shorter than STABLE_CYCLES never reach the outputs.

## Timing
- Let edge N be the first edge at which seg_in is sampled with the new pattern, and seg_in is held afterwards.
- Accept-driven outputs (digit, digit_valid, illegal, illegal_cnt, update, wrap) change at edge N+STABLE_CYCLES+2.
- update and wrap go high at that edge and fall at the next edge.
- A change at edge N+k, with k < STABLE_CYCLES+2, restarts the latency from N+k.
- If RESET_N is asserted mid-settle, the FSM returns to SETTLE with cnt = 0, last = 0, and all outputs at their reset values. After release, a constant input is accepted once, STABLE_CYCLES+2 edges after the first sampling edge.
- No combinational path from seg_in to any output.

## Configuration
- SEG7_CAPTURE_TENS_EN defined:
  - tens and wrap ports exist.
  - A legal accept of 0 whose previous state was digit_valid = 1 with digit 9 increments tens modulo 10 (9 wraps to 0).
  - wrap pulses in the same cycle as update.
  - Blank or illegal accepts between the 9 and the 0 break the sequence: a following 0 does not wrap.
- Undefined: tens and wrap logic and ports are absent; all other behaviour is identical.

## Structure
- Package seg7_pkg:
  - the 16 segment-code constants for 0–F, shared with the display encoder;
  - SEG_BLANK = 7'h7F;
  - FSM state enum {SETTLE, LOCKED};
  - counter width constant CNT_W = 20.
- Sub-module seg7_to_hex (combinational): seg[6:0] -> value[3:0], match, blank. This is the inverse of the existing encoder table and can be reused elsewhere.

## Test plan
- Reset, STABLE_CYCLES = 4, seg_in = 7'h30 (digit 3) from edge 0 -> digit = 3, digit_valid = 1, and update pulses for one cycle, all at edge 6. Holding the pattern for 100 more cycles produces no further update.
- From the stable 3, drive a 2-cycle glitch to 7'h24 and then return to 7'h30 -> digit stays 3, no update, illegal_cnt stays 0.
- Drive 7'h7E, then hold -> at acceptance illegal = 1, digit_valid = 0, digit stays 3, illegal_cnt = 1. Then drive 7'h7F -> at acceptance illegal = 0, digit_valid = 0, no count.
- 300 alternating illegal patterns, each held for 6 cycles -> illegal_cnt saturates at 255 and does not wrap.
- With SEG7_CAPTURE_TENS_EN, sequence 8, 9, 0, 1, 9, 0 with each pattern held -> tens = 2 at the end, with wrap pulses coinciding with the two 0 updates. The sequence 9, blank, 0 -> no wrap.
- Assert RESET_N low mid-settle (cnt = 2) for 1 cycle while seg_in stays constant -> all outputs are 0 immediately. After release, exactly one accept occurs, STABLE_CYCLES+2 edges after the first sampling edge.
